// File: rtl/zigzag_rle_encoder.sv
`default_nettype none
// =============================================================================
// Module   : zigzag_rle_encoder
// Purpose  : Latches one zigzag-ordered 8x8 coefficient block and emits
//            JPEG-style (run, size, amplitude) symbols: DC, AC, ZRL and EOB.
// Options  : RLE_DC_DPCM_EN - DC symbol codes the difference to the previous DC
// Revision : 1.0 - initial release
// =============================================================================
module zigzag_rle_encoder #(
    parameter int COEF_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [64*COEF_WIDTH-1:0] zigzag_pix_in,
    output logic                     sym_valid,
    input  logic                     sym_ready,
    output logic [3:0]               sym_run,
    output logic [3:0]               sym_size,
    output logic [8:0]               sym_amp,
    output logic                     sym_is_dc,
    output logic                     sym_last,
    output logic                     busy,
    output logic                     done
);

    localparam int         c_BLK_W    = 64 * COEF_WIDTH;
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_DC    = 3'd1;
    localparam logic [2:0] c_ST_SCAN  = 3'd2;
    localparam logic [2:0] c_ST_ZRL   = 3'd3;
    localparam logic [2:0] c_ST_EOB   = 3'd4;
    localparam logic [2:0] c_ST_FLUSH = 3'd5;

    logic [2:0]         r_state, w_state_nxt;
    logic [c_BLK_W-1:0] r_blk;
    logic [5:0]         r_run, w_run_nxt;
    logic [5:0]         r_k, w_k_nxt;
    logic               r_valid, r_is_dc, r_last, r_done;
    logic [3:0]         r_sym_run, r_sym_size;
    logic [8:0]         r_sym_amp;

    logic                  w_adv, w_load, w_latch, w_done_nxt;
    logic                  w_coef_zero, w_k_last, w_run_ovf;
    logic [3:0]            w_sym_run, w_sym_size;
    logic [8:0]            w_sym_amp;
    logic                  w_sym_dc, w_sym_last;
    logic [COEF_WIDTH-1:0] w_coefs [64];
    logic [COEF_WIDTH-1:0] w_coef;
    logic signed [9:0]     w_dc_val, w_ac_val;
    logic [12:0]           w_dc_enc, w_ac_enc;

    // Returns {size[3:0], amp[8:0]}; negative amplitudes are (v-1) truncated to size bits.
    function automatic logic [12:0] f_encode(input logic signed [9:0] v);
        logic [9:0] mag;
        logic [3:0] sz;
        logic [9:0] mask;
        logic [9:0] amp;
        mag = v[9] ? 10'(-v) : 10'(v);
        sz  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (mag[i]) sz = 4'(i + 1);
        end
        mask = (10'd1 << sz) - 10'd1;
        amp  = (v[9] ? 10'(v - 10'sd1) : 10'(v)) & mask;
        return {sz, amp[8:0]};
    endfunction

    for (genvar g = 0; g < 64; g++) begin : g_coef
        assign w_coefs[g] = r_blk[c_BLK_W-1-COEF_WIDTH*g -: COEF_WIDTH];
    end

    assign w_coef      = w_coefs[r_k];
    assign w_coef_zero = (w_coef == '0);
    assign w_k_last    = (r_k == 6'd63);
    assign w_run_ovf   = (r_run[5:4] != 2'b00);
    assign w_adv       = !r_valid || sym_ready;
    assign w_ac_val    = 10'(signed'(w_coef));
    assign w_ac_enc    = f_encode(w_ac_val);
    assign w_dc_enc    = f_encode(w_dc_val);

`ifdef RLE_DC_DPCM_EN
    logic [COEF_WIDTH-1:0] r_prev_dc;

    assign w_dc_val = 10'(signed'(w_coefs[0])) - 10'(signed'(r_prev_dc));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_prev_dc <= '0;
        else if (r_valid && r_is_dc && sym_ready)
            r_prev_dc <= w_coefs[0];
    end
`else
    assign w_dc_val = 10'(signed'(w_coefs[0]));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_nxt = c_ST_DC;
            c_ST_DC:    if (w_adv) w_state_nxt = c_ST_SCAN;
            c_ST_SCAN: begin
                if (w_coef_zero) begin
                    if (w_k_last) w_state_nxt = c_ST_EOB;
                end else if (w_run_ovf) begin
                    w_state_nxt = c_ST_ZRL;
                end else if (w_adv && w_k_last) begin
                    w_state_nxt = c_ST_FLUSH;
                end
            end
            // Leaving ZRL once the post-subtract run drops below 16.
            c_ST_ZRL:   if (w_adv && (r_run < 6'd32)) w_state_nxt = c_ST_SCAN;
            c_ST_EOB:   if (w_adv) w_state_nxt = c_ST_FLUSH;
            c_ST_FLUSH: if (r_valid && sym_ready) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_latch    = 1'b0;
        w_load     = 1'b0;
        w_done_nxt = 1'b0;
        w_run_nxt  = r_run;
        w_k_nxt    = r_k;
        w_sym_run  = 4'd0;
        w_sym_size = 4'd0;
        w_sym_amp  = 9'd0;
        w_sym_dc   = 1'b0;
        w_sym_last = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_latch   = 1'b1;
                    w_run_nxt = 6'd0;
                    w_k_nxt   = 6'd1;
                end
            end
            c_ST_DC: begin
                if (w_adv) begin
                    w_load     = 1'b1;
                    w_sym_dc   = 1'b1;
                    w_sym_size = w_dc_enc[12:9];
                    w_sym_amp  = w_dc_enc[8:0];
                end
            end
            c_ST_SCAN: begin
                if (w_coef_zero) begin
                    w_run_nxt = r_run + 6'd1;
                    if (!w_k_last) w_k_nxt = r_k + 6'd1;
                end else if (!w_run_ovf && w_adv) begin
                    w_load     = 1'b1;
                    w_sym_run  = r_run[3:0];
                    w_sym_size = w_ac_enc[12:9];
                    w_sym_amp  = w_ac_enc[8:0];
                    w_sym_last = w_k_last;
                    w_run_nxt  = 6'd0;
                    if (!w_k_last) w_k_nxt = r_k + 6'd1;
                end
            end
            c_ST_ZRL: begin
                if (w_adv) begin
                    w_load    = 1'b1;
                    w_sym_run = 4'd15;
                    w_run_nxt = r_run - 6'd16;
                end
            end
            c_ST_EOB: begin
                if (w_adv) begin
                    w_load     = 1'b1;
                    w_sym_last = 1'b1;
                end
            end
            c_ST_FLUSH: w_done_nxt = r_valid && sym_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_blk      <= '0;
            r_run      <= 6'd0;
            r_k        <= 6'd0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_sym_run  <= 4'd0;
            r_sym_size <= 4'd0;
            r_sym_amp  <= 9'd0;
            r_is_dc    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            if (w_latch) r_blk <= zigzag_pix_in;
            r_run  <= w_run_nxt;
            r_k    <= w_k_nxt;
            r_done <= w_done_nxt;
            if (w_load) begin
                r_valid    <= 1'b1;
                r_sym_run  <= w_sym_run;
                r_sym_size <= w_sym_size;
                r_sym_amp  <= w_sym_amp;
                r_is_dc    <= w_sym_dc;
                r_last     <= w_sym_last;
            end else if (sym_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sym_valid = r_valid;
    assign sym_run   = r_sym_run;
    assign sym_size  = r_sym_size;
    assign sym_amp   = r_sym_amp;
    assign sym_is_dc = r_is_dc;
    assign sym_last  = r_last;
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_zigzag_rle_encoder.sv
`default_nettype none
// =============================================================================
// Module   : tb_zigzag_rle_encoder
// Purpose  : Directed and randomized bench for zigzag_rle_encoder with a
//            symbol-list reference model and random consumer backpressure.
// Revision : 1.0 - initial release
// =============================================================================
module tb_zigzag_rle_encoder;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sym_ready = 1'b0;
    logic [511:0] zigzag_pix_in = '0;
    logic         sym_valid, sym_is_dc, sym_last, busy, done;
    logic [3:0]   sym_run, sym_size;
    logic [8:0]   sym_amp;

    int           checks = 0;
    int           errors = 0;
    int           coef [64];
    int           model_prev_dc = 0;
    logic [18:0]  exp_q [$];
    int           span;

    zigzag_rle_encoder #(.COEF_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .zigzag_pix_in(zigzag_pix_in),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_run      (sym_run),
        .sym_size     (sym_size),
        .sym_amp      (sym_amp),
        .sym_is_dc    (sym_is_dc),
        .sym_last     (sym_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Symbol = {run, size, amp, is_dc, last}; size is the bit length of |v|.
    function automatic logic [18:0] mk_sym(input int run, input int v, input bit dc, input bit last);
        int m, s, a;
        m = (v < 0) ? -v : v;
        s = 0;
        while ((1 << s) <= m) s++;
        a = (v >= 0) ? v : v + (1 << s) - 1;
        return {4'(run), 4'(s), 9'(a), dc, last};
    endfunction

    task automatic build_expected();
        int dcv, run, lastnz;
        exp_q.delete();
`ifdef RLE_DC_DPCM_EN
        dcv = coef[0] - model_prev_dc;
        model_prev_dc = coef[0];
`else
        dcv = coef[0];
`endif
        exp_q.push_back(mk_sym(0, dcv, 1'b1, 1'b0));
        lastnz = 0;
        for (int k = 1; k < 64; k++) if (coef[k] != 0) lastnz = k;
        run = 0;
        for (int k = 1; k <= lastnz; k++) begin
            if (coef[k] == 0) begin
                run++;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back(mk_sym(15, 0, 1'b0, 1'b0));
                    run -= 16;
                end
                exp_q.push_back(mk_sym(run, coef[k], 1'b0, k == 63));
                run = 0;
            end
        end
        if (lastnz < 63) exp_q.push_back(mk_sym(0, 0, 1'b0, 1'b1));
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [511:0] pack_block();
        logic [511:0] b;
        for (int k = 0; k < 64; k++) b[511-8*k -: 8] = 8'(coef[k]);
        return b;
    endfunction

    task automatic fill_random(input int zero_pct);
        for (int k = 0; k < 64; k++) begin
            if (int'($urandom_range(0, 99)) < zero_pct) coef[k] = 0;
            else begin
                do coef[k] = int'($urandom_range(0, 255)) - 128; while (coef[k] == 0);
            end
        end
    endtask

    task automatic fill_zero();
        for (int k = 0; k < 64; k++) coef[k] = 0;
    endtask

    task automatic run_block(input bit rand_ready, input bit hold_start, output int blk_span);
        logic [18:0] obs, held, e;
        int          cyc, early_done;
        bit          got_last, done_seen, stalled;
        build_expected();
        start = 1'b1;
        zigzag_pix_in = pack_block();
        sym_ready = 1'b0;
        @(posedge clock); #1;
        if (!hold_start) start = 1'b0;
        zigzag_pix_in = rand512();
        check("busy_after_start", {31'd0, busy}, 1);
        @(posedge clock); #1;
        check("dc_valid_latency", {30'd0, sym_valid, sym_is_dc}, 2'b11);
        cyc = 0; early_done = 0; blk_span = 0;
        got_last = 1'b0; done_seen = 1'b0; stalled = 1'b0; held = '0;
        while (!done_seen && cyc < 1000) begin
            zigzag_pix_in = rand512();
            obs = {sym_run, sym_size, sym_amp, sym_is_dc, sym_last};
            if (stalled) check("stall_hold", {13'd0, obs}, {13'd0, held});
            if (got_last) begin
                check("done_after_last", {29'd0, done, busy, sym_valid}, 3'b100);
                done_seen = 1'b1;
                start = 1'b0;
            end else begin
                if (done) early_done++;
                sym_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (sym_valid && sym_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
                    check("symbol", {13'd0, obs}, {13'd0, e});
                    if (sym_last) begin
                        got_last = 1'b1;
                        blk_span = cyc + 1;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = sym_valid;
                    held = obs;
                end
            end
            cyc++;
            @(posedge clock); #1;
        end
        check("block_completed", {31'd0, done_seen}, 1);
        check("symbols_left", exp_q.size(), 0);
        check("early_done", early_done, 0);
        check("done_one_cycle", {31'd0, done}, 0);
    endtask

    initial begin
        #1;
        check("reset_outputs", {8'd0, sym_valid, sym_run, sym_size, sym_amp, sym_is_dc, sym_last, busy, done}, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        // All-zero AC, DC=5: DC symbol then a single EOB, 65 cycles end to end.
        fill_zero(); coef[0] = 5;
        run_block(1'b0, 1'b0, span);
        check("zero_block_span", span, 65);

        // DC=-3, k1=-1, long zero run ending in k63=127: three ZRLs, no EOB.
        fill_zero(); coef[0] = -3; coef[1] = -1; coef[63] = 127;
        run_block(1'b0, 1'b0, span);

        // Single ZRL followed by (1,1,1); start held high and ignored while busy.
        fill_zero(); coef[0] = int'($urandom_range(0, 255)) - 128; coef[18] = 1;
        run_block(1'b0, 1'b1, span);

        // Dense block with ready held: one symbol per cycle.
        fill_random(0);
        run_block(1'b0, 1'b0, span);
        check("dense_block_span", span, 64);

        // Random blocks under random backpressure.
        for (int i = 0; i < 3; i++) begin
            fill_random(0);
            run_block(1'b1, 1'b0, span);
        end
        for (int i = 0; i < 3; i++) begin
            fill_random(85);
            run_block(1'b1, 1'b0, span);
        end
        fill_random(97); coef[63] = -128;
        run_block(1'b1, 1'b0, span);

        // Reset while the DC symbol is stalled, then restart cleanly.
        fill_random(30);
        start = 1'b1; zigzag_pix_in = pack_block(); sym_ready = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("stalled_dc_valid", {30'd0, sym_valid, sym_is_dc}, 2'b11);
        reset = 1'b1;
        #1;
        check("midblock_reset_outputs", {8'd0, sym_valid, sym_run, sym_size, sym_amp, sym_is_dc, sym_last, busy, done}, 0);
        @(posedge clock); #1;
        check("held_reset_outputs", {8'd0, sym_valid, sym_run, sym_size, sym_amp, sym_is_dc, sym_last, busy, done}, 0);
        reset = 1'b0;
        model_prev_dc = 0;
        @(posedge clock); #1;

        // DC=100 then DC=-100: raw or differential depending on build.
        fill_zero(); coef[0] = 100;
        run_block(1'b0, 1'b0, span);
        fill_zero(); coef[0] = -100;
        run_block(1'b1, 1'b0, span);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
